systolic_skew_feeder: RTL and testbench

// - Transmit side of the 2-D FP16 systolic array's operand interface: buffers one tile of A columns and B rows, then drives Current_A1..N / Current_B1..N with the diagonal skew.
// - Lane i is delayed i cycles and zero-padded. Sits between the tile loader and the PE array.
// - Owns the array's start line and consumes its done pulse to close each tile.

---
 rtl/systolic_skew_feeder_if.sv | 29 ++
 rtl/systolic_skew_feeder.sv | 197 +++++++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_skew_feeder_if.sv
// Operand/handshake bundle between tile loader, skew feeder and PE array.
// The slave modport is the feeder's view; master is the loader/array side.
interface systolic_skew_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 5
);
  logic                    tile_start;
  logic [2:0]              k_len;
  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] in_a;
  logic [N*DATA_WIDTH-1:0] in_b;
  logic [N*DATA_WIDTH-1:0] cur_a;
  logic [N*DATA_WIDTH-1:0] cur_b;
  logic [2:0]              filter_size;
  logic                    arr_start;
  logic                    arr_done;
  logic                    tile_done;

  modport slave (
    input  tile_start, k_len, in_valid, in_a, in_b, arr_done,
    output in_ready, cur_a, cur_b, filter_size, arr_start, tile_done
  );

  modport master (
    output tile_start, k_len, in_valid, in_a, in_b, arr_done,
    input  in_ready, cur_a, cur_b, filter_size, arr_start, tile_done
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Buffers one tile of A columns / B rows and streams them diagonally skewed into the PE array.
// Optional FEEDER_STALL_CNT_EN adds a saturating stall_cnt output.
module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 5,
  parameter int MAX_K      = 7
) (
  input  logic clk,
  input  logic reset,
`ifdef FEEDER_STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  systolic_skew_feeder_if.slave bus
);

  localparam int CW  = $clog2(MAX_K + 2*N);
  localparam int CW1 = CW + 1;
  localparam int KW  = (MAX_K > 1) ? $clog2(MAX_K) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   wptr_r, wptr_s;
  logic [CW-1:0]   t_r, t_s;
  logic [2:0]      filter_r, filter_s;
  logic            in_ready_r, in_ready_s;
  logic            arr_start_r, arr_start_s;
  logic            tile_done_r, tile_done_s;
  logic            xfer_s;
  logic [3:0]      k_wide_s;
  logic [2:0]      k_eff_s;
  logic [CW-1:0]   k_last_s;
  logic [CW-1:0]   t_last_s;

  logic [DATA_WIDTH-1:0] a_buf_r [MAX_K][N];
  logic [DATA_WIDTH-1:0] b_buf_r [MAX_K][N];
  logic [DATA_WIDTH-1:0] a_lane_s [N];
  logic [DATA_WIDTH-1:0] b_lane_s [N];
  logic [DATA_WIDTH-1:0] a_lane_r [N];
  logic [DATA_WIDTH-1:0] b_lane_r [N];

  assign xfer_s   = (state_r == LOAD) && in_ready_r && bus.in_valid;
  assign k_last_s = CW'(filter_r) - CW'(1);
  assign t_last_s = CW'(filter_r) + CW'(N - 2);

  // k_len of 0 means one vector; anything beyond the buffer depth is clamped
  always_comb begin
    k_wide_s = {1'b0, bus.k_len};
    if (k_wide_s == 4'd0) begin
      k_eff_s = 3'd1;
    end else if (k_wide_s > 4'(MAX_K)) begin
      k_eff_s = 3'(MAX_K);
    end else begin
      k_eff_s = k_wide_s[2:0];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s     = state_r;
    wptr_s      = wptr_r;
    t_s         = t_r;
    filter_s    = filter_r;
    tile_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.tile_start) begin
          filter_s = k_eff_s;
          wptr_s   = '0;
          state_s  = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (xfer_s) begin
          wptr_s = wptr_r + CW'(1);
          if (wptr_r == k_last_s) begin
            t_s     = '0;
            state_s = STREAM;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      STREAM: begin
        if (t_r == t_last_s) begin
          t_s     = '0;
          state_s = WAIT;
        end else begin
          t_s = t_r + CW'(1);
        end
      end
      WAIT: begin
        if (bus.arr_done) begin
          tile_done_s = 1'b1;
          state_s     = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    in_ready_s  = (state_s == LOAD);
    arr_start_s = (state_s == STREAM) || (state_s == WAIT);
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      wptr_r      <= '0;
      t_r         <= '0;
      filter_r    <= 3'd0;
      in_ready_r  <= 1'b0;
      arr_start_r <= 1'b0;
      tile_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      wptr_r      <= wptr_s;
      t_r         <= t_s;
      filter_r    <= filter_s;
      in_ready_r  <= in_ready_s;
      arr_start_r <= arr_start_s;
      tile_done_r <= tile_done_s;
    end
  end

  // Tile buffer: contents are don't-care after reset, so it carries no reset
  always_ff @(posedge clk) begin
    if (xfer_s) begin
      for (int i = 0; i < N; i++) begin
        a_buf_r[wptr_r[KW-1:0]][i] <= bus.in_a[i*DATA_WIDTH +: DATA_WIDTH];
        b_buf_r[wptr_r[KW-1:0]][i] <= bus.in_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Lane i shows vector t-i; the borrow bit of the widened subtraction flags t < i
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [CW1-1:0] rel_s;
    logic           hit_s;
    assign rel_s = {1'b0, t_r} - CW1'(i);
    assign hit_s = (state_r == STREAM) && !rel_s[CW] && (rel_s[CW-1:0] < CW'(filter_r));
    assign a_lane_s[i] = hit_s ? a_buf_r[rel_s[KW-1:0]][i] : '0;
    assign b_lane_s[i] = hit_s ? b_buf_r[rel_s[KW-1:0]][i] : '0;
    assign bus.cur_a[i*DATA_WIDTH +: DATA_WIDTH] = a_lane_r[i];
    assign bus.cur_b[i*DATA_WIDTH +: DATA_WIDTH] = b_lane_r[i];
  end

  // Registered skewed lanes
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        a_lane_r[i] <= '0;
        b_lane_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        a_lane_r[i] <= a_lane_s[i];
        b_lane_r[i] <= b_lane_s[i];
      end
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.arr_start   = arr_start_r;
  assign bus.tile_done   = tile_done_r;
  assign bus.filter_size = filter_r;

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of offered-but-refused cycles, restarted per tile
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_r <= 16'd0;
    end else if ((state_r == IDLE) && bus.tile_start) begin
      stall_cnt_r <= 16'd0;
    end else if (bus.in_valid && !in_ready_r && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: directed tiles plus random tiles
// compared against a matrix-level model of the diagonal skew.
module tb_systolic_skew_feeder;
  localparam int DW    = 16;
  localparam int N     = 5;
  localparam int MAX_K = 7;
  localparam int VW    = N * DW;

  logic clk;
  logic reset;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  systolic_skew_feeder_if #(.DATA_WIDTH(DW), .N(N)) ifc ();

  systolic_skew_feeder #(.DATA_WIDTH(DW), .N(N), .MAX_K(MAX_K)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef FEEDER_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;
  int kexp;
  logic [DW-1:0] mA [N][MAX_K];
  logic [DW-1:0] mB [MAX_K][N];
  logic [VW-1:0] obs_a [MAX_K + 2*N];

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected lanes after the edge ending skew step t (t<0 means no step yet)
  function automatic logic [VW-1:0] exp_a(input int t);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (t - i >= 0 && t - i < kexp) v[i*DW +: DW] = mA[i][t-i];
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] exp_b(input int t);
    logic [VW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) begin
      if (t - j >= 0 && t - j < kexp) v[j*DW +: DW] = mB[t-j][j];
    end
    return v;
  endfunction

  task automatic fill_directed();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < MAX_K; k++) begin
        mA[i][k] = 16'(256 * i + k);
        mB[k][i] = 16'(4096 * k + i);
      end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < MAX_K; k++) begin
        mA[i][k] = 16'($urandom);
        mB[k][i] = 16'($urandom);
      end
  endtask

  task automatic do_start(input int k);
    ifc.tile_start = 1'b1;
    ifc.k_len      = 3'(k);
    kexp = (k == 0) ? 1 : ((k > MAX_K) ? MAX_K : k);
    @(negedge clk);
    ifc.tile_start = 1'b0;
    check("filter_size_latch", ifc.filter_size, kexp);
    check("in_ready_enter_load", ifc.in_ready, 1);
    check("arr_start_load", ifc.arr_start, 0);
    check("tile_done_one_cycle", ifc.tile_done, 0);
`ifdef FEEDER_STALL_CNT_EN
    check("stall_cnt_clear", stall_cnt, 0);
`endif
  endtask

  task automatic do_load(input bit toggle);
    int k;
    int cyc;
    bit v;
    k = 0;
    cyc = 0;
    while (k < kexp && cyc < 64) begin
      check("in_ready_load", ifc.in_ready, 1);
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      ifc.in_valid   = v;
      ifc.arr_done   = 1'b1;
      ifc.tile_start = (cyc == 1);
      ifc.k_len      = 3'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) begin
        ifc.in_a[i*DW +: DW] = v ? mA[i][k] : 16'($urandom);
        ifc.in_b[i*DW +: DW] = v ? mB[k][i] : 16'($urandom);
      end
      @(negedge clk);
      cyc++;
      if (v) k++;
    end
    ifc.in_valid   = 1'b0;
    ifc.arr_done   = 1'b0;
    ifc.tile_start = 1'b0;
    check("load_cycles", cyc, toggle ? 2 * kexp - 1 : kexp);
    check("in_ready_drop", ifc.in_ready, 0);
    check("filter_size_hold", ifc.filter_size, kexp);
    check("arr_start_rise", ifc.arr_start, 1);
  endtask

  task automatic do_stream(input bit stall);
    for (int s = 0; s < kexp + N; s++) begin
      check("arr_start_stream", ifc.arr_start, 1);
      check("cur_a", ifc.cur_a, exp_a(s - 1));
      check("cur_b", ifc.cur_b, exp_b(s - 1));
      if (s > 0) obs_a[s-1] = ifc.cur_a;
      ifc.in_valid = stall && (s < 10);
      @(negedge clk);
    end
    ifc.in_valid = 1'b0;
`ifdef FEEDER_STALL_CNT_EN
    if (stall) check("stall_cnt_10", stall_cnt, 10);
`endif
  endtask

  task automatic do_wait(input int n);
    for (int c = 0; c < n; c++) begin
      check("arr_start_wait", ifc.arr_start, 1);
      check("cur_a_wait_zero", ifc.cur_a, 0);
      check("cur_b_wait_zero", ifc.cur_b, 0);
      check("tile_done_wait", ifc.tile_done, 0);
      @(negedge clk);
    end
    ifc.arr_done = 1'b1;
    @(negedge clk);
    ifc.arr_done = 1'b0;
    check("tile_done_pulse", ifc.tile_done, 1);
    check("arr_start_gap", ifc.arr_start, 0);
    check("cur_a_idle_zero", ifc.cur_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b0;
    ifc.tile_start = 1'b0;
    ifc.k_len = 3'd0;
    ifc.in_valid = 1'b0;
    ifc.in_a = '0;
    ifc.in_b = '0;
    ifc.arr_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check("rst_in_ready", ifc.in_ready, 0);
    check("rst_arr_start", ifc.arr_start, 0);
    check("rst_tile_done", ifc.tile_done, 0);
    check("rst_cur_a", ifc.cur_a, 0);
    check("rst_cur_b", ifc.cur_b, 0);
    check("rst_filter_size", ifc.filter_size, 0);

    // Directed K=3 tile with the reference pattern
    fill_directed();
    do_start(3);
    do_load(1'b0);
    do_stream(1'b0);
    check("t0_only_lane0", obs_a[0], 0);
    check("t4_lane4", obs_a[4][4*DW +: DW], 16'h0400);
    check("t4_lane2", obs_a[4][2*DW +: DW], 16'h0202);
    check("last_lanes0to3", obs_a[6][4*DW-1:0], 0);
    check("last_lane4", obs_a[6][4*DW +: DW], 16'h0402);
    do_wait(2);

    // Back-to-back: k_len=0 is treated as K=1
    fill_random();
    do_start(0);
    do_load(1'b0);
    do_stream(1'b0);
    do_wait(0);

    // K=7 with toggling valid, stalls offered during STREAM, long WAIT
    fill_random();
    do_start(7);
    do_load(1'b1);
    do_stream(1'b1);
    do_wait(20);

    fill_random();
    do_start(5);
    do_load(1'b0);
    do_stream(1'b0);
    do_wait(1);

    // Reset in the middle of STREAM
    @(negedge clk);
    fill_random();
    do_start(3);
    do_load(1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrst_in_ready", ifc.in_ready, 0);
    check("midrst_arr_start", ifc.arr_start, 0);
    check("midrst_cur_a", ifc.cur_a, 0);
    check("midrst_cur_b", ifc.cur_b, 0);
    check("midrst_filter_size", ifc.filter_size, 0);
    @(negedge clk);
    check("midrst_idle_arr_start", ifc.arr_start, 0);
    check("midrst_idle_in_ready", ifc.in_ready, 0);

    // Random tiles
    for (int r = 0; r < 6; r++) begin
      fill_random();
      do_start(int'($urandom_range(0, 7)));
      do_load(1'($urandom_range(0, 1)));
      do_stream(1'b0);
      do_wait(int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
